// File: rtl/mdc_reorder.sv
// Ping-pong reorder buffer: turns the two bit-reversed lanes of a 32-point MDC FFT
// into a single natural-order stream, one complex sample per cycle.
module mdc_reorder #(
  parameter int WIDTH = 9
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic                    in_sof,
  input  logic signed [WIDTH-1:0] in_up_re,
  input  logic signed [WIDTH-1:0] in_up_im,
  input  logic signed [WIDTH-1:0] in_dn_re,
  input  logic signed [WIDTH-1:0] in_dn_im,
  output logic                    out_valid,
  output logic                    out_sof,
  output logic signed [WIDTH-1:0] out_re,
  output logic signed [WIDTH-1:0] out_im,
  output logic [4:0]              out_idx,
  output logic                    overrun
);

  typedef enum logic {W_IDLE, W_FILL} wr_state_t;

  wr_state_t        wr_state;
  logic             wr_bank;
  logic [3:0]       wr_k;
  logic [1:0]       full;
  logic             rd_bank;
  logic [4:0]       rd_addr;

  logic             wr_en;
  logic             wr_last;
  logic [3:0]       wr_pair;
  logic [3:0]       wr_row;
  logic             rd_issue;
  logic             rd_done;
  logic [2*WIDTH-1:0] rd_word;

  // bitrev5(2k) always has MSB 0 and bitrev5(2k+1) MSB 1, so each lane owns one half
  // of the 32 addresses and needs only a single write port per bank.
  logic [2*WIDTH-1:0] up_mem [0:31];
  logic [2*WIDTH-1:0] dn_mem [0:31];

  always_comb begin
    wr_en   = 1'b0;
    wr_pair = 4'd0;
    case (wr_state)
      W_IDLE: wr_en = in_valid && in_sof && !full[wr_bank];
      W_FILL: begin
        wr_en   = in_valid;
        wr_pair = in_sof ? 4'd0 : wr_k;
      end
      default: ;
    endcase
    wr_last = wr_en && (wr_pair == 4'd15);
  end

  assign wr_row = {wr_pair[0], wr_pair[1], wr_pair[2], wr_pair[3]};

  always_ff @(posedge clk) begin
    if (wr_en) begin
      up_mem[{wr_bank, wr_row}] <= {in_up_re, in_up_im};
      dn_mem[{wr_bank, wr_row}] <= {in_dn_re, in_dn_im};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state <= W_IDLE;
      wr_k     <= 4'd0;
      wr_bank  <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      case (wr_state)
        W_IDLE: begin
          if (in_valid && in_sof) begin
            if (full[wr_bank]) begin
              overrun <= 1'b1;
            end else begin
              wr_k     <= 4'd1;
              wr_state <= W_FILL;
            end
          end
        end
        W_FILL: begin
          if (in_valid) begin
            if (wr_last) begin
              wr_k     <= 4'd0;
              wr_bank  <= ~wr_bank;
              wr_state <= W_IDLE;
            end else begin
              wr_k <= wr_pair + 4'd1;
            end
          end
        end
        default: wr_state <= W_IDLE;
      endcase
    end
  end

  // A full read bank means a readout is in progress; rd_addr wraps back to 0 after 31.
  assign rd_issue = full[rd_bank];
  assign rd_done  = rd_issue && (rd_addr == 5'd31);
  assign rd_word  = rd_addr[4] ? dn_mem[{rd_bank, rd_addr[3:0]}]
                               : up_mem[{rd_bank, rd_addr[3:0]}];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_bank <= 1'b0;
      rd_addr <= 5'd0;
    end else if (rd_issue) begin
      rd_addr <= rd_addr + 5'd1;
      if (rd_done) begin
        rd_bank <= ~rd_bank;
      end
    end
  end

  // Writer and reader never touch the same bank's flag in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 2'b00;
    end else begin
      if (wr_last) begin
        full[wr_bank] <= 1'b1;
      end
      if (rd_done) begin
        full[rd_bank] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_idx   <= 5'd0;
      out_re    <= '0;
      out_im    <= '0;
    end else if (rd_issue) begin
      out_valid <= 1'b1;
      out_sof   <= (rd_addr == 5'd0);
      out_idx   <= rd_addr;
      out_re    <= rd_word[2*WIDTH-1:WIDTH];
      out_im    <= rd_word[WIDTH-1:0];
    end else begin
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_idx   <= 5'd0;
      out_re    <= '0;
      out_im    <= '0;
    end
  end

endmodule
